// File: rtl/ptb_word_arbiter_pkg.sv
// Shared types and default sizing for the random-word arbiter slice.
package ptb_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        FULL = 2'd2
    } arb_state_t;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_WORD_W = 8;
    localparam int DEF_DROP_W = 8;

endpackage

// File: rtl/ptb_word_arbiter_if.sv
// Bit-stream input, requester handshake and status outputs of the word arbiter.
interface ptb_word_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 8,
    parameter int DROP_W = 8
);
    logic              i_ptb;
    logic              i_ptb_valid;
    logic              i_flush;
    logic [N_REQ-1:0]  i_req;
    logic [N_REQ-1:0]  o_gnt;
    logic [WORD_W-1:0] o_word;
    logic              o_word_rdy;
    logic [DROP_W-1:0] o_drop_cnt;

    modport master (
        output i_ptb, i_ptb_valid, i_flush, i_req,
        input  o_gnt, o_word, o_word_rdy, o_drop_cnt
    );

    modport slave (
        input  i_ptb, i_ptb_valid, i_flush, i_req,
        output o_gnt, o_word, o_word_rdy, o_drop_cnt
    );
endinterface

// File: rtl/ptb_word_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, then wraps below it.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt
);
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[k] && (k >= int'(ptr))) begin
                gnt[k] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[k] && (k < int'(ptr))) begin
                gnt[k] = 1'b1;
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ptb_word_arbiter.sv
// Packs the serial LFSR bit stream into words and hands them out round-robin, one word per grant.
module ptb_word_arbiter
    import ptb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int WORD_W = DEF_WORD_W,
    parameter int DROP_W = DEF_DROP_W
) (
    input logic              clk,
    input logic              rst_n,
    ptb_word_arbiter_if.slave bus
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(WORD_W);

    arb_state_t        state, state_n;
    logic [WORD_W-1:0] acc, acc_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [WORD_W-1:0] hold, hold_n;
    logic [WORD_W-1:0] word, word_n;
    logic [N_REQ-1:0]  gnt, gnt_n;
    logic [DROP_W-1:0] drop, drop_n;
    logic [PW-1:0]     ptr, ptr_n;

    logic [N_REQ-1:0]  arb_gnt;
    logic [PW-1:0]     win;
    logic [PW-1:0]     next_ptr;
    logic [WORD_W-1:0] shifted;
    logic              completes;
    logic              grant;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req (bus.i_req),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    always_comb begin
        win = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (arb_gnt[k]) win = PW'(k);
        end
        next_ptr = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            acc   <= '0;
            cnt   <= '0;
            hold  <= '0;
            word  <= '0;
            gnt   <= '0;
            drop  <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            hold  <= hold_n;
            word  <= word_n;
            gnt   <= gnt_n;
            drop  <= drop_n;
            ptr   <= ptr_n;
        end
    end

    // In FULL the accumulator itself holds the pending word; count has already wrapped to 0.
    always_comb begin
        state_n   = state;
        acc_n     = acc;
        cnt_n     = cnt;
        hold_n    = hold;
        word_n    = word;
        gnt_n     = '0;
        drop_n    = drop;
        ptr_n     = ptr;
        shifted   = {acc[WORD_W-2:0], bus.i_ptb};
        completes = bus.i_ptb_valid && (cnt == CW'(WORD_W - 1));
        grant     = (state != FILL) && (|bus.i_req);

        if (bus.i_flush) begin
            acc_n   = '0;
            cnt_n   = '0;
            state_n = FILL;
        end else begin
            if (grant) begin
                gnt_n  = arb_gnt;
                word_n = hold;
                ptr_n  = next_ptr;
            end
            case (state)
                FILL: begin
                    if (bus.i_ptb_valid) begin
                        acc_n = shifted;
                        cnt_n = completes ? '0 : cnt + CW'(1);
                        if (completes) begin
                            hold_n  = shifted;
                            state_n = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.i_ptb_valid) begin
                        acc_n = shifted;
                        cnt_n = completes ? '0 : cnt + CW'(1);
                    end
                    if (completes) begin
                        if (grant) hold_n  = shifted;
                        else       state_n = FULL;
                    end else if (grant) begin
                        state_n = FILL;
                    end
                end
                FULL: begin
                    if (grant) begin
                        hold_n  = acc;
                        state_n = HOLD;
                        if (bus.i_ptb_valid) begin
                            acc_n = {{(WORD_W-1){1'b0}}, bus.i_ptb};
                            cnt_n = CW'(1);
                        end else begin
                            acc_n = '0;
                            cnt_n = '0;
                        end
                    end else if (bus.i_ptb_valid && (drop != '1)) begin
                        drop_n = drop + DROP_W'(1);
                    end
                end
                default: state_n = FILL;
            endcase
        end
    end

    assign bus.o_gnt      = gnt;
    assign bus.o_word     = word;
    assign bus.o_word_rdy = (state != FILL);
    assign bus.o_drop_cnt = drop;
endmodule
